gshare_predictor: RTL
=====================

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 The block SHALL have parameter IDX_W, default 7, giving the PC/history/index width; the table holds 2^IDX_W entries.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port areset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port predict_valid, input, 1 bit: a prediction is requested this cycle.
REQ-005 The block SHALL have port predict_pc, input, IDX_W bits: the PC being predicted.
REQ-006 The block SHALL have port predict_taken, output, 1 bit: the predicted direction.
REQ-007 The block SHALL have port predict_history, output, IDX_W bits: the global history used for this prediction.
REQ-008 The block SHALL have port train_valid, input, 1 bit: a training update is presented this cycle.
REQ-009 The block SHALL have port train_taken, input, 1 bit: the resolved branch outcome.
REQ-010 The block SHALL have port train_mispredicted, input, 1 bit: the resolved branch was mispredicted.
REQ-011 The block SHALL have port train_history, input, IDX_W bits: the history captured at prediction time.
REQ-012 The block SHALL have port train_pc, input, IDX_W bits: the PC of the resolved branch.

Function
REQ-013 The block SHALL hold a pattern history table (PHT) of 2^IDX_W 2-bit saturating counters and an IDX_W-bit global history register (GHR).
REQ-014 The prediction index SHALL be predict_pc XOR GHR; predict_taken SHALL be counter[1] of the indexed entry, combinational with zero latency.
REQ-015 predict_history SHALL equal the current GHR, combinationally, regardless of predict_valid.
REQ-016 When train_valid=1, entry train_pc XOR train_history SHALL update at the next edge: +1 saturating at 2'b11 when taken, -1 saturating at 2'b00 when not taken.
REQ-017 When train_valid=1 and train_mispredicted=1, the GHR SHALL load {train_history[IDX_W-2:0], train_taken} at the next edge.
REQ-018 Otherwise, when predict_valid=1, the GHR SHALL load {GHR[IDX_W-2:0], predict_taken} at the next edge.
REQ-019 Mispredict recovery SHALL take precedence over a simultaneous prediction's GHR update; the PHT training write SHALL still occur.
REQ-020 A prediction and a training write to the same index in one cycle SHALL read the pre-update counter (see REQ-025 for the exception).
REQ-021 train_mispredicted SHALL be ignored when train_valid=0; with both valids low, all state SHALL hold.

Reset
REQ-022 While areset=1, the GHR SHALL be 0 and every PHT entry SHALL be 2'b01 (weakly not-taken), asynchronously and including mid-operation.
REQ-023 After reset, predict_taken SHALL be 0 and predict_history SHALL be 0 for every PC.

Configuration
REQ-024 The macro GSHARE_TRAIN_BYPASS_EN SHALL select the same-index read/write behaviour.
REQ-025 With GSHARE_TRAIN_BYPASS_EN defined, a same-cycle same-index prediction SHALL see the post-training counter value; without it, the pre-update value.

Structure
REQ-026 The shared package gshare_pkg SHALL hold the 2-bit counter typedef, the reset constant CNT_WEAK_NT = 2'b01, and a saturating next-counter function.
REQ-027 The PHT storage and its write port SHALL be a sub-module named gshare_pht; GHR and recovery logic SHALL live in the top module.

Verification
REQ-028 Reset, then predict_valid=1, pc=0x00 -> predict_taken=0, predict_history=0x00; after the edge GHR=0x00.
REQ-029 Two trains with pc=0x2A, history=0x00, taken=1 -> entry 0x2A goes 01->10->11; predict pc=0x2A with GHR=0 -> taken=1.
REQ-030 Five taken trains at index 0x2A stay at 11; four not-taken trains -> 10, 01, 00, 00.
REQ-031 GHR=0x55; same cycle predict_valid=1 plus train mispredicted, history=0x12, taken=1 -> GHR=0x25 next cycle.
REQ-032 Entry 0x05 at 01; train pc=0x05, history=0, taken=1 while predicting pc=0x05, GHR=0 -> predict_taken=0 without the macro, 1 with it.
REQ-033 areset pulsed mid-stream with GHR=0x7F and trained entries -> GHR=0x00 and all entries 01 immediately, without waiting for a clock.

Source files
------------

// File: rtl/gshare_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gshare_pkg
// Description : Shared types and helpers for the gshare branch predictor.
//               Holds the 2-bit saturating counter type, its reset value
//               (weakly not-taken) and the saturating next-counter function.
// Revision    : 1.0 - initial release
// ============================================================================
package gshare_pkg;

    typedef logic [1:0] cnt_t;

    // Reset value of every PHT entry: weakly not-taken.
    localparam cnt_t CNT_WEAK_NT = 2'b01;

    // Saturating update: count up toward 2'b11 on taken,
    // down toward 2'b00 on not-taken.
    function automatic cnt_t cnt_next(input cnt_t cnt, input logic taken);
        cnt_t r_res;
        r_res = cnt;
        if (taken) begin
            if (cnt != 2'b11) r_res = cnt + 2'b01;
        end else begin
            if (cnt != 2'b00) r_res = cnt - 2'b01;
        end
        return r_res;
    endfunction

endpackage : gshare_pkg
`default_nettype wire

// File: rtl/gshare_pht.sv
`default_nettype none
// ============================================================================
// Module      : gshare_pht
// Description : Pattern history table: 2^IDX_W two-bit saturating counters
//               with one combinational read port and one training write port.
//               All entries reset asynchronously to weakly not-taken.
//               Build macro GSHARE_TRAIN_BYPASS_EN: when defined, a read that
//               hits the index being trained in the same cycle returns the
//               post-training counter; otherwise the stored (pre-update) one.
// Ports       : clk       - clock
//               areset    - asynchronous active-high reset
//               rd_idx    - read index
//               rd_taken  - predicted direction (counter MSB)
//               wr_en     - training write enable
//               wr_idx    - training index
//               wr_taken  - resolved outcome used to step the counter
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_pht
    import gshare_pkg::*;
#(
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int c_depth = 1 << IDX_W;

    cnt_t r_cnt [c_depth];
    cnt_t w_rd_cnt;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_cnt[i] <= CNT_WEAK_NT;
            end
        end else if (wr_en) begin
            r_cnt[wr_idx] <= cnt_next(r_cnt[wr_idx], wr_taken);
        end
    end

`ifdef GSHARE_TRAIN_BYPASS_EN
    // Forward the in-flight training result to a same-index read.
    always_comb begin
        w_rd_cnt = r_cnt[rd_idx];
        if (wr_en && (wr_idx == rd_idx)) begin
            w_rd_cnt = cnt_next(r_cnt[wr_idx], wr_taken);
        end
    end
`else
    always_comb begin
        w_rd_cnt = r_cnt[rd_idx];
    end
`endif

    // Upper half of the counter range (10, 11) predicts taken.
    assign rd_taken = (w_rd_cnt >= 2'b10);

endmodule : gshare_pht
`default_nettype wire

// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module      : gshare_predictor
// Description : Gshare branch direction predictor. Prediction index is
//               predict_pc XOR global history; training index is
//               train_pc XOR the history captured at prediction time.
//               A mispredicted training update restores the global history
//               from the training history plus the real outcome, and wins
//               over a simultaneous speculative history shift.
//               Build macro GSHARE_TRAIN_BYPASS_EN (see gshare_pht) selects
//               whether a same-cycle same-index prediction sees the trained
//               counter value.
// Ports       : clk                - clock
//               areset             - asynchronous active-high reset
//               predict_valid      - prediction requested this cycle
//               predict_pc         - PC being predicted
//               predict_taken      - predicted direction (combinational)
//               predict_history    - current global history (combinational)
//               train_valid        - training update presented this cycle
//               train_taken        - resolved outcome
//               train_mispredicted - resolved branch was mispredicted
//               train_history      - history captured at prediction time
//               train_pc           - PC of the resolved branch
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_predictor
    import gshare_pkg::*;
#(
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             predict_valid,
    input  logic [IDX_W-1:0] predict_pc,
    output logic             predict_taken,
    output logic [IDX_W-1:0] predict_history,
    input  logic             train_valid,
    input  logic             train_taken,
    input  logic             train_mispredicted,
    input  logic [IDX_W-1:0] train_history,
    input  logic [IDX_W-1:0] train_pc
);

    logic [IDX_W-1:0] r_ghr;
    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_train_idx;
    logic             w_pred_taken;

    assign w_pred_idx  = predict_pc ^ r_ghr;
    assign w_train_idx = train_pc ^ train_history;

    gshare_pht #(
        .IDX_W (IDX_W)
    ) u_pht (
        .clk      (clk),
        .areset   (areset),
        .rd_idx   (w_pred_idx),
        .rd_taken (w_pred_taken),
        .wr_en    (train_valid),
        .wr_idx   (w_train_idx),
        .wr_taken (train_taken)
    );

    // Recovery rebuilds the history as it should have been after the
    // resolved branch; otherwise a prediction shifts in its own guess.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_ghr <= '0;
        end else if (train_valid && train_mispredicted) begin
            r_ghr <= {train_history[IDX_W-2:0], train_taken};
        end else if (predict_valid) begin
            r_ghr <= {r_ghr[IDX_W-2:0], w_pred_taken};
        end
    end

    assign predict_taken   = w_pred_taken;
    assign predict_history = r_ghr;

endmodule : gshare_predictor
`default_nettype wire
